ex_stage: RTL and testbench

Execute stage of the pipeline: the consumer of the ID/EX latch outputs. It selects ALU operands, computes the ALU result, the branch target and the destination register, and registers everything into the EX/MEM boundary. Single-cycle ALU ops complete in one clock. MULT runs on an iterative 32-cycle shift-add multiplier and holds the ID/EX latch with `stall` until the product is registered.

---
 rtl/ex_pkg.sv | 26 ++
 rtl/mul_seq.sv | 62 ++++++
 rtl/ex_stage.sv | 143 ++++++++++++++
 tb/tb_ex_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU function codes, FSM states, multiplier length.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ex_pkg;

    // alu_op function codes
    localparam logic [5:0] OP_MULT = 6'h18;
    localparam logic [5:0] OP_ADD  = 6'h20;
    localparam logic [5:0] OP_SUB  = 6'h22;
    localparam logic [5:0] OP_AND  = 6'h24;
    localparam logic [5:0] OP_OR   = 6'h25;
    localparam logic [5:0] OP_XOR  = 6'h26;
    localparam logic [5:0] OP_NOR  = 6'h27;
    localparam logic [5:0] OP_SLT  = 6'h2A;
    localparam logic [5:0] OP_SLTU = 6'h2B;

    // One conditional add-and-shift per cycle, one cycle per multiplier bit
    localparam int MUL_CYCLES = 32;
    localparam int MUL_CNT_W  = $clog2(MUL_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ex_state_t;

endpackage

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier producing the low DATA_W bits of the unsigned product.
// Latency: load on start, then MUL_CYCLES steps; product is valid combinationally while last=1.
// Backpressure: none; abort returns it to idle at the next edge, overriding start.
//
// Ports: clk, rst_n (async active-low); start loads a/b; abort kills any operation;
//        busy = operation in flight; last = final step this cycle; product = acc after this step.
module mul_seq
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              last,
    output logic [DATA_W-1:0] product
);

    logic [DATA_W-1:0]    a_sh;
    logic [DATA_W-1:0]    b_sh;
    logic [DATA_W-1:0]    acc;
    logic [DATA_W-1:0]    acc_next;
    logic [MUL_CNT_W-1:0] cnt;

    assign acc_next = b_sh[0] ? (acc + a_sh) : acc;
    assign last     = busy && (cnt == MUL_CNT_W'(MUL_CYCLES - 1));
    // The final step's sum is exposed directly so the caller can register it
    // on the same edge the step would otherwise complete.
    assign product  = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            a_sh <= a;
            b_sh <= b;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            acc  <= acc_next;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + MUL_CNT_W'(1);
            if (last) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand muxes, ALU, branch target, destination select, EX/MEM output registers.
// Latency: 1 edge for single-cycle ops; 33 edges for MULT (iterative multiplier).
// Backpressure: stall (combinational) holds ID/EX for 32 cycles per MULT; flush clears it at once.
//
// Ports: clk, rst_n (async active-low); ID/EX inputs (in_valid, alu_op, control bits, pc_next,
//        data1/data2/sign_extend, reg1/reg2); flush; stall out; registered EX/MEM *_reg outputs.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [5:0]        alu_op,
    input  logic              reg_dst,
    input  logic              alu_src,
    input  logic              branch,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic [PC_W-1:0]   pc_next,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] sign_extend,
    input  logic [4:0]        reg1,
    input  logic [4:0]        reg2,
    input  logic              flush,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] alu_result_reg,
    output logic [DATA_W-1:0] store_data_reg,
    output logic [PC_W-1:0]   branch_target_reg,
    output logic              zero_reg,
    output logic [4:0]        write_reg_reg,
    output logic              branch_reg,
    output logic              mem_write_reg,
    output logic              mem_read_reg,
    output logic              reg_write_reg,
    output logic              mem_to_reg_reg
);

    ex_state_t         state;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] result;
    logic              is_mult;
    logic              take_mult;
    logic              done_vld;
    logic              mul_busy;
    logic              mul_last;
    logic [DATA_W-1:0] mul_product;

    assign op_b      = alu_src ? sign_extend : data2;
    assign is_mult   = (alu_op == OP_MULT);
    assign take_mult = (state == IDLE) && in_valid && is_mult;

    // Held high from the cycle MULT is presented until the cycle its last step
    // runs, so the product and the still-held control fields register together.
    assign stall = !flush && (take_mult || ((state == BUSY) && mul_busy && !mul_last));

    // A result leaves the stage for a single-cycle op from IDLE, or on the
    // multiplier's last step; everything else sends a bubble.
    assign done_vld = !flush && (((state == IDLE) && in_valid && !is_mult) ||
                                 ((state == BUSY) && mul_last));

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = data1 + op_b;
            OP_SUB:  alu_res = data1 - op_b;
            OP_AND:  alu_res = data1 & op_b;
            OP_OR:   alu_res = data1 | op_b;
            OP_XOR:  alu_res = data1 ^ op_b;
            OP_NOR:  alu_res = ~(data1 | op_b);
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(data1) < $signed(op_b))};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (data1 < op_b)};
            default: alu_res = '0;
        endcase
    end

    assign result = (state == BUSY) ? mul_product : alu_res;

    mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (take_mult && !flush),
        .abort   (flush),
        .a       (data1),
        .b       (op_b),
        .busy    (mul_busy),
        .last    (mul_last),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (take_mult) state <= BUSY;
                BUSY:    if (mul_last)  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Data fields update every cycle; out_valid alone tells downstream whether to use them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid         <= 1'b0;
            alu_result_reg    <= '0;
            store_data_reg    <= '0;
            branch_target_reg <= '0;
            zero_reg          <= 1'b0;
            write_reg_reg     <= '0;
            branch_reg        <= 1'b0;
            mem_write_reg     <= 1'b0;
            mem_read_reg      <= 1'b0;
            reg_write_reg     <= 1'b0;
            mem_to_reg_reg    <= 1'b0;
        end else begin
            out_valid         <= done_vld;
            alu_result_reg    <= result;
            store_data_reg    <= data2;
            branch_target_reg <= pc_next + sign_extend[PC_W-1:0];
            zero_reg          <= (result == '0);
            write_reg_reg     <= reg_dst ? reg2 : reg1;
            branch_reg        <= branch;
            mem_write_reg     <= mem_write;
            mem_read_reg      <= mem_read;
            reg_write_reg     <= reg_write;
            mem_to_reg_reg    <= mem_to_reg;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes model results, monitor pops on out_valid.
// Latency: checks 1-edge single ops and 33-edge MULT completion cycles.
// Backpressure: driver honours stall; counts stall cycles per instruction.
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [5:0]  alu_op;
    logic        reg_dst, alu_src, branch, mem_write, mem_read, reg_write, mem_to_reg;
    logic [7:0]  pc_next;
    logic [31:0] data1, data2, sign_extend;
    logic [4:0]  reg1, reg2;
    logic        flush;
    logic        stall, out_valid, zero_reg;
    logic [31:0] alu_result_reg, store_data_reg;
    logic [7:0]  branch_target_reg;
    logic [4:0]  write_reg_reg;
    logic        branch_reg, mem_write_reg, mem_read_reg, reg_write_reg, mem_to_reg_reg;

    always #5 clk = ~clk;

    ex_stage #(.DATA_W(32), .PC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_op(alu_op),
        .reg_dst(reg_dst), .alu_src(alu_src), .branch(branch), .mem_write(mem_write),
        .mem_read(mem_read), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .pc_next(pc_next), .data1(data1), .data2(data2), .sign_extend(sign_extend),
        .reg1(reg1), .reg2(reg2), .flush(flush), .stall(stall), .out_valid(out_valid),
        .alu_result_reg(alu_result_reg), .store_data_reg(store_data_reg),
        .branch_target_reg(branch_target_reg), .zero_reg(zero_reg),
        .write_reg_reg(write_reg_reg), .branch_reg(branch_reg),
        .mem_write_reg(mem_write_reg), .mem_read_reg(mem_read_reg),
        .reg_write_reg(reg_write_reg), .mem_to_reg_reg(mem_to_reg_reg)
    );

    typedef struct {
        logic [5:0]  op;
        logic        reg_dst, alu_src, branch, mem_write, mem_read, reg_write, mem_to_reg;
        logic [7:0]  pc;
        logic [31:0] d1, d2, se;
        logic [4:0]  r1, r2;
    } instr_t;

    typedef struct {
        logic [31:0] res;
        logic [31:0] store;
        logic [7:0]  tgt;
        logic        zero;
        logic [4:0]  wr;
        logic [4:0]  ctl;
        int          due;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    instr_t t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference behaviour straight from the instruction semantics.
    function automatic exp_t model(input instr_t i);
        exp_t        e;
        logic [31:0] b;
        logic [63:0] p;
        b = i.alu_src ? i.se : i.d2;
        p = {32'd0, i.d1} * {32'd0, b};
        case (i.op)
            OP_ADD:  e.res = i.d1 + b;
            OP_SUB:  e.res = i.d1 - b;
            OP_AND:  e.res = i.d1 & b;
            OP_OR:   e.res = i.d1 | b;
            OP_XOR:  e.res = i.d1 ^ b;
            OP_NOR:  e.res = ~(i.d1 | b);
            OP_SLT:  e.res = ($signed(i.d1) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: e.res = (i.d1 < b) ? 32'd1 : 32'd0;
            OP_MULT: e.res = p[31:0];
            default: e.res = 32'd0;
        endcase
        e.store = i.d2;
        e.tgt   = i.pc + i.se[7:0];
        e.zero  = (e.res == 32'd0);
        e.wr    = i.reg_dst ? i.r2 : i.r1;
        e.ctl   = {i.branch, i.mem_write, i.mem_read, i.reg_write, i.mem_to_reg};
        e.due   = 0;
        return e;
    endfunction

    function automatic instr_t zero_i();
        instr_t i;
        i.op = OP_ADD; i.reg_dst = 0; i.alu_src = 0; i.branch = 0; i.mem_write = 0;
        i.mem_read = 0; i.reg_write = 0; i.mem_to_reg = 0; i.pc = 0;
        i.d1 = 0; i.d2 = 0; i.se = 0; i.r1 = 0; i.r2 = 0;
        return i;
    endfunction

    function automatic instr_t rand_i();
        instr_t i;
        case ($urandom_range(0, 10))
            0: i.op = OP_ADD;   1: i.op = OP_SUB;   2: i.op = OP_AND;
            3: i.op = OP_OR;    4: i.op = OP_XOR;   5: i.op = OP_NOR;
            6: i.op = OP_SLT;   7: i.op = OP_SLTU;  8: i.op = OP_MULT;
            9: i.op = 6'h00;    default: i.op = 6'h3F;
        endcase
        {i.reg_dst, i.alu_src, i.branch, i.mem_write} = 4'($urandom);
        {i.mem_read, i.reg_write, i.mem_to_reg} = 3'($urandom);
        i.pc = 8'($urandom);
        i.d1 = $urandom;
        i.d2 = ($urandom_range(0, 4) == 0) ? i.d1 : $urandom;
        i.se = ($urandom_range(0, 1) == 0) ? 32'($signed(8'($urandom))) : $urandom;
        i.r1 = 5'($urandom);
        i.r2 = 5'($urandom);
        return i;
    endfunction

    task automatic apply(input instr_t i);
        alu_op = i.op; reg_dst = i.reg_dst; alu_src = i.alu_src; branch = i.branch;
        mem_write = i.mem_write; mem_read = i.mem_read; reg_write = i.reg_write;
        mem_to_reg = i.mem_to_reg; pc_next = i.pc; data1 = i.d1; data2 = i.d2;
        sign_extend = i.se; reg1 = i.r1; reg2 = i.r2;
    endtask

    // Present one instruction, hold it while stalled; returns just after the consuming edge.
    task automatic issue(input instr_t i);
        exp_t e;
        int   n;
        apply(i);
        in_valid = 1'b1;
        e = model(i);
        e.due = cyc + ((i.op == OP_MULT) ? 33 : 1);
        sb.push_back(e);
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 100) begin
                $display("FAIL stall_timeout: got stall stuck high want release");
                break;
            end
        end
        check("stall_cycles", 64'(n), (i.op == OP_MULT) ? 64'd32 : 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ctl"}, {stall, out_valid, zero_reg, write_reg_reg, branch_reg,
               mem_write_reg, mem_read_reg, reg_write_reg, mem_to_reg_reg}, 64'd0);
        check({tag, "_data"}, {alu_result_reg, store_data_reg}, 64'd0);
        check({tag, "_tgt"}, 64'(branch_target_reg), 64'd0);
    endtask

    // Monitor: every valid output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: got out_valid=1 want 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("latency", 64'(cyc), 64'(mon_e.due));
                check("alu_result", 64'(alu_result_reg), 64'(mon_e.res));
                check("fields", {store_data_reg, branch_target_reg, zero_reg, write_reg_reg,
                                 branch_reg, mem_write_reg, mem_read_reg, reg_write_reg,
                                 mem_to_reg_reg},
                      {mon_e.store, mon_e.tgt, mon_e.zero, mon_e.wr, mon_e.ctl});
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        apply(zero_i());
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD 5+7
        t = zero_i(); t.op = OP_ADD; t.d1 = 5; t.d2 = 7; t.reg_write = 1;
        issue(t);
        check("add_5_7", {out_valid, zero_reg, alu_result_reg}, {1'b1, 1'b0, 32'd12});

        // ADD with immediate -1 gives zero, rt selected
        t = zero_i(); t.op = OP_ADD; t.alu_src = 1; t.se = 32'hFFFF_FFFF; t.d1 = 1;
        t.r1 = 3; t.r2 = 9;
        issue(t);
        check("add_imm_zero", {zero_reg, write_reg_reg, alu_result_reg}, {1'b1, 5'd3, 32'd0});

        // SLT / SLTU on -1 vs 1
        t = zero_i(); t.op = OP_SLT; t.d1 = 32'hFFFF_FFFF; t.d2 = 1;
        issue(t);
        check("slt_neg", 64'(alu_result_reg), 64'd1);
        t.op = OP_SLTU;
        issue(t);
        check("sltu_big", 64'(alu_result_reg), 64'd0);

        // Branch target wraps
        t = zero_i(); t.op = OP_SUB; t.branch = 1; t.pc = 8'hFE; t.se = 3; t.reg_dst = 1;
        t.r2 = 17;
        issue(t);
        check("branch_wrap", {branch_reg, branch_target_reg, write_reg_reg}, {1'b1, 8'h01, 5'd17});

        // MULT then back-to-back MULT
        t = zero_i(); t.op = OP_MULT; t.d1 = 7; t.d2 = 6;
        issue(t);
        check("mult_7_6", {out_valid, alu_result_reg}, {1'b1, 32'd42});
        t = zero_i(); t.op = OP_MULT; t.d1 = 32'hFFFF_FFFF; t.d2 = 2;
        issue(t);
        check("mult_wrap", {out_valid, alu_result_reg}, {1'b1, 32'hFFFF_FFFE});

        // Flush at count 10
        t = zero_i(); t.op = OP_MULT; t.d1 = 9; t.d2 = 9;
        apply(t);
        in_valid = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        check("mult_mid_stall", 64'(stall), 64'd1);
        flush = 1'b1;
        #1;
        check("flush_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        t = zero_i(); t.op = OP_OR; t.d1 = 32'h00F0; t.d2 = 32'h0F00;
        issue(t);
        check("after_flush_or", {out_valid, alu_result_reg}, {1'b1, 32'h0FF0});

        // Reset at count 20
        t = zero_i(); t.op = OP_MULT; t.d1 = 123; t.d2 = 45; t.pc = 8'h40; t.se = 1;
        t.r1 = 7; t.reg_write = 1; t.branch = 1;
        apply(t);
        in_valid = 1'b1;
        repeat (21) @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_outs("midmul_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        t = zero_i(); t.op = OP_ADD; t.d1 = 100; t.d2 = 23;
        issue(t);
        check("after_reset_add", {out_valid, alu_result_reg}, {1'b1, 32'd123});

        // Random traffic with bubbles
        repeat (150) begin
            if ($urandom_range(0, 3) == 0) begin
                apply(rand_i());
                in_valid = 1'b0;
                @(negedge clk);
                check("bubble_stall", 64'(stall), 64'd0);
                @(posedge clk);
                #1;
            end
            issue(rand_i());
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
